// File: rtl/alu_issue_wb.sv
// Operand-issue / writeback sequencer around an external combinational 32-bit ALU.
// Instructions are taken one at a time, read from an 8x32 register file, condition-checked, executed and retired.
module alu_issue_wb #(
    parameter int NREG = 8,
    parameter int IMMW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [3:0]  alu_cm,
    output logic [31:0] alu_num1,
    output logic [31:0] alu_num2,
    input  logic [31:0] alu_num3,
    input  logic [3:0]  alu_fl,
    output logic        done_valid,
    output logic        done_skipped,
    output logic [2:0]  done_rd,
    output logic [31:0] done_data,
    output logic [3:0]  flags,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_instr;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [3:0]  r_cmr;
    logic        r_exec;
    logic [31:0] r_res;
    logic [3:0]  r_fres;
    logic [3:0]  r_flags;
    logic [31:0] r_rf [NREG];
    logic        r_in_ready;
    logic        r_done_valid;
    logic        r_done_skipped;
    logic [2:0]  r_done_rd;
    logic [31:0] r_done_data;

    logic [3:0]    w_cond;
    logic [3:0]    w_cm;
    logic          w_s;
    logic          w_i;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rn;
    logic [AW-1:0] w_rm;
    logic [31:0]   w_imm;
    logic          w_cond_ok;

    // Condition field against flags {N,Z,C,V}; codes 8..15 always pass.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] fl);
        logic ok;
        case (cond)
            4'd0:    ok = fl[2];
            4'd1:    ok = ~fl[2];
            4'd2:    ok = fl[1];
            4'd3:    ok = ~fl[1];
            4'd4:    ok = fl[3];
            4'd5:    ok = ~fl[3];
            4'd6:    ok = fl[0];
            4'd7:    ok = ~fl[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    assign w_cond    = r_instr[31:28];
    assign w_cm      = r_instr[27:24];
    assign w_s       = r_instr[23];
    assign w_i       = r_instr[22];
    assign w_rd      = r_instr[21:19];
    assign w_rn      = r_instr[18:16];
    assign w_rm      = r_instr[2:0];
    assign w_imm     = {{(32-IMMW){1'b0}}, r_instr[IMMW-1:0]};
    assign w_cond_ok = cond_pass(w_cond, r_flags);

    assign in_ready     = r_in_ready;
    assign alu_cm       = r_cmr;
    assign alu_num1     = r_opa;
    assign alu_num2     = r_opb;
    assign done_valid   = r_done_valid;
    assign done_skipped = r_done_skipped;
    assign done_rd      = r_done_rd;
    assign done_data    = r_done_data;
    assign flags        = r_flags;
    assign dbg_data     = r_rf[dbg_addr];

    // Next-state logic; a failed condition bypasses EXEC.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_cond_ok) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, register file, flags and retire outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr        <= 32'd0;
            r_opa          <= 32'd0;
            r_opb          <= 32'd0;
            r_cmr          <= 4'd0;
            r_exec         <= 1'b0;
            r_res          <= 32'd0;
            r_fres         <= 4'd0;
            r_flags        <= 4'd0;
            r_in_ready     <= 1'b1;
            r_done_valid   <= 1'b0;
            r_done_skipped <= 1'b0;
            r_done_rd      <= 3'd0;
            r_done_data    <= 32'd0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else begin
            r_in_ready     <= (w_state_nxt == S_IDLE);
            r_done_valid   <= 1'b0;
            r_done_skipped <= 1'b0;
            r_done_rd      <= 3'd0;
            r_done_data    <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_instr <= in_instr;
                    end
                end
                S_READ: begin
                    // r_rf[0] is never written, so r0 reads as zero without special-casing.
                    r_opa  <= r_rf[w_rn];
                    r_opb  <= w_i ? w_imm : r_rf[w_rm];
                    r_cmr  <= w_cm;
                    r_exec <= w_cond_ok;
                    if (!w_cond_ok) begin
                        r_done_valid   <= 1'b1;
                        r_done_skipped <= 1'b1;
                        r_done_rd      <= w_rd;
                    end
                end
                S_EXEC: begin
                    r_res        <= alu_num3;
                    r_fres       <= alu_fl;
                    r_done_valid <= 1'b1;
                    r_done_rd    <= w_rd;
                    r_done_data  <= alu_num3;
                end
                S_WB: begin
                    if (r_exec) begin
                        if (w_rd != {AW{1'b0}}) begin
                            r_rf[w_rd] <= r_res;
                        end
                        if (w_s) begin
                            r_flags <= r_fres;
                        end
                    end
                end
                default: begin
                    r_exec <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Sequencing stage wrapped around the combinational 32-bit ALU (4-bit op code `cm`, operands `num1`/`num2`, result `num3`, flags `FL` = {N,Z,C,V}).
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x32 register file.
- Evaluates a condition field against the stored flags, drives the ALU, then writes back the result and optionally updates the flags register.
- Sits directly upstream (operand issue) and downstream (writeback) of the ALU.

Parameters:
- NREG, 8, number of registers; address width is log2(NREG) = 3.
- IMMW, 16, immediate width; zero-extended to 32 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word; format below.
- alu_cm  out  4  op code to ALU.
- alu_num1  out  32  operand A to ALU.
- alu_num2  out  32  operand B to ALU.
- alu_num3  in  32  ALU result, combinational from the alu_* outputs.
- alu_fl  in  4  ALU flags {N,Z,C,V}.
- done_valid  out  1  one-cycle pulse per retired instruction.
- done_skipped  out  1  valid with done_valid; 1 = condition failed, no effects.
- done_rd  out  3  destination register of the retired instruction.
- done_data  out  32  value written; 0 when skipped.
- flags  out  4  architectural flags register {N,Z,C,V}.
- dbg_addr  in  3  debug register read address.
- dbg_data  out  32  combinational read of rf[dbg_addr].

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low, asynchronously and regardless of state:
    - FSM to IDLE.
    - All registers, including every rf entry and flags, to 0.
    - All outputs to 0 except in_ready = 1.
    - Any in-flight instruction is dropped: no write, no done pulse.
- Instruction format:
  - [31:28] cond, [27:24] cm, [23] S (update flags), [22] I (immediate).
  - [21:19] rd, [18:16] rn.
  - [2:0] rm when I=0; [15:0] imm when I=1.
- Register file:
  - r0 reads as 0; writes to r0 are discarded, but still retire with a done pulse.
- Condition codes:
  - 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 4 MI N=1; 5 PL N=0; 6 VS V=1; 7 VC V=0.
  - 8..15: always execute.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE:
    - in_ready = 1.
    - On in_valid=1, latch in_instr and go to READ.
    - in_ready is 0 in every other state.
  - READ:
    - opa <= rf[rn].
    - opb <= I ? zero-extended imm : rf[rm].
    - cmr <= cm.
    - Evaluate cond against the current flags register; latch result as exec.
    - exec=1 -> EXEC; exec=0 -> WB.
  - EXEC:
    - alu_cm/alu_num1/alu_num2 are driven from cmr/opa/opb.
    - At the clock edge, capture alu_num3 into res and alu_fl into fres.
  - WB:
    - If exec:
      - rf[rd] <= res, unless rd=0.
      - If S=1, flags <= fres.
      - done_data = res, done_skipped = 0.
    - If not exec: no rf or flags change; done_data = 0, done_skipped = 1.
    - done_valid = 1 for exactly this cycle.
    - Next state is IDLE.
- ALU outputs:
  - alu_cm/num1/num2 hold their last latched values outside EXEC.
  - They are 0 after reset.
- Latency:
  - Accept edge to done_valid: 3 cycles when executed, 2 cycles when skipped.
  - Throughput: one instruction per 4 cycles executed, per 3 cycles skipped.
- Hazards:
  - WB completes before the next instruction's READ, so back-to-back dependent instructions see the updated register and flags.
  - There is no forwarding logic.
- Undefined cm values: the ALU returns 0; the stage writes 0 normally and, if S=1, updates flags with the ALU's flags.
- dbg_data:
  - Purely combinational read.
  - In the WB cycle it shows the old value; the new value is visible from the following cycle.
- in_valid while not ready: ignored. The source must hold the instruction until in_ready=1.

Test Plan:
1. Reset, then dbg reads r0..r7 -> all 0; flags=0; in_ready=1; done_valid=0.
2. Issue `cm=4, I=1, rd=1, rn=0, imm=0x0005, cond=14`:
   - done_valid exactly 3 cycles after accept.
   - done_data=5; dbg r1=5; flags unchanged (S=0).
3. With r1=5, issue `cm=2, S=1, I=0, rd=2, rn=1, rm=1`:
   - r2=0; flags Z bit = 1.
   - Then issue EQ-conditioned `cm=4, I=1, rd=3, imm=7`: executes, r3=7.
   - Then issue NE-conditioned `rd=4`: done_skipped=1 two cycles after accept; r4 stays 0.
4. Write to r0 (`cm=4, I=1, rd=0, imm=9`):
   - done_valid=1 with done_data=9.
   - dbg r0 still reads 0.
5. Hold in_valid=1 continuously with a stream of 3 instructions:
   - in_ready high only in IDLE.
   - Exactly 3 done pulses, spaced 4 cycles apart.
6. Assert rst_n=0 during EXEC of an r5 write:
   - No done pulse; r5=0; FSM in IDLE.
   - Next instruction completes with normal latency.
